// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin two-producer arbiter for a shared FIFO write port
// Optional bounded-burst grants are enabled by defining FIFO_ARB_BURST_EN.
module fifo_write_arbiter #(
    parameter int WIDTH = 6,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             fifo_full_n,
    output logic             fifo_write_en,
    output logic [WIDTH-1:0] fifo_data,
    output logic [1:0]       grant
);

    if (BURST < 1 || BURST > 16) begin : g_burst_range
        $error("fifo_write_arbiter: BURST must be in 1..16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   last_nxt;
    logic   gnt0;
    logic   gnt1;
    logic   own_valid;
    logic   beat;
    logic   burst_end;
    logic   rel_grant;

    assign gnt0      = (state == GNT0);
    assign gnt1      = (state == GNT1);
    assign own_valid = (gnt0 && req0_valid) || (gnt1 && req1_valid);
    assign beat      = own_valid && fifo_full_n;

    // A stalled FIFO never releases: only a dropped valid or the final burst beat does.
    assign rel_grant = (gnt0 || gnt1) && (!own_valid || (beat && burst_end));

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(BURST) + 1;

    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_nxt;

    assign burst_end = (beat_cnt == CW'(BURST - 1));

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (rel_grant) begin
            beat_cnt_nxt = '0;
        end else if (beat) begin
            beat_cnt_nxt = beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
        end else begin
            beat_cnt <= beat_cnt_nxt;
        end
    end
`else
    assign burst_end = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (req0_valid) begin
                    state_nxt = GNT0;
                end else if (req1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (rel_grant) begin
                    last_nxt  = 1'b0;
                    state_nxt = req1_valid ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (rel_grant) begin
                    last_nxt  = 1'b1;
                    state_nxt = req0_valid ? GNT0 : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req0_ready    = gnt0 && fifo_full_n;
    assign req1_ready    = gnt1 && fifo_full_n;
    assign fifo_write_en = beat;
    assign grant         = {gnt1, gnt0};

    always_comb begin
        fifo_data = '0;
        if (gnt0) begin
            fifo_data = req0_data;
        end else if (gnt1) begin
            fifo_data = req1_data;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int WIDTH = 6;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_data = '0;
    logic             req1_ready;
    logic             fifo_full_n = 1'b1;
    logic             fifo_write_en;
    logic [WIDTH-1:0] fifo_data;
    logic [1:0]       grant;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .fifo_full_n(fifo_full_n),
        .fifo_write_en(fifo_write_en),
        .fifo_data(fifo_data),
        .grant(grant)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_count = 0;
    int first_wr = 0;
    int last_wr = 0;
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] exp_q[$];
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Producer models: hold valid/data until the word is accepted at a posedge.
    initial begin
        forever begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            req0_valid = (q0.size() > 0);
            req0_data  = (q0.size() > 0) ? q0[0] : '0;
            req1_valid = (q1.size() > 0);
            req1_data  = (q1.size() > 0) ? q1[0] : '0;
        end
    end

    // Monitor: every FIFO write is compared against the expected-word queue.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n && fifo_write_en) begin
                if (wr_count == 0) first_wr = cyc;
                last_wr = cyc;
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_write: got %0h expected no write", fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    if (fifo_data !== e) begin
                        errors++;
                        $display("FAIL fifo_data: got %0h expected %0h", fifo_data, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wr(input int n, input string name);
        int k;
        k = 0;
        while (wr_count < n && k < 50) begin
            tick();
            k++;
        end
        if (wr_count < n) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d writes expected %0d", name, wr_count, n);
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && k < 100) begin
            tick();
            k++;
        end
        chk(name, exp_q.size() + q0.size() + q1.size(), 0);
        tick();
        tick();
    endtask

    task automatic start_phase();
        wr_count = 0;
        first_wr = 0;
        last_wr  = 0;
    endtask

    initial begin
        // Both producers valid out of reset
        tick();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(WIDTH'(16 + i));
            q1.push_back(WIDTH'(32 + i));
        end
`ifdef FIFO_ARB_BURST_EN
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(WIDTH'(16 + 4 * b + i));
            for (int i = 0; i < 4; i++) exp_q.push_back(WIDTH'(32 + 4 * b + i));
        end
`else
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(WIDTH'(16 + i));
            exp_q.push_back(WIDTH'(32 + i));
        end
`endif
        tick();
        tick();
        chk("reset_grant", {30'd0, grant}, 0);
        chk("reset_ready0", {31'd0, req0_ready}, 0);
        chk("reset_ready1", {31'd0, req1_ready}, 0);
        chk("reset_write_en", {31'd0, fifo_write_en}, 0);
        chk("reset_fifo_data", {26'd0, fifo_data}, 0);
        start_phase();
        reset_n = 1'b1;
        wait_drain("both_drain");
        chk("both_no_bubble_span", last_wr - first_wr, 15);

        // Single producer 0 stream, with grant latency
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start_phase();
        for (int i = 1; i <= 5; i++) begin
            q0.push_back(WIDTH'(i));
            exp_q.push_back(WIDTH'(i));
        end
        tick();
        chk("latency_grant_before", {30'd0, grant}, 0);
        tick();
        chk("latency_grant_after", {30'd0, grant}, 1);
        wait_drain("single_drain");
`ifdef FIFO_ARB_BURST_EN
        chk("single_span", last_wr - first_wr, 5);
`else
        chk("single_span", last_wr - first_wr, 8);
`endif

        // FIFO stall after two beats
        start_phase();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(WIDTH'(48 + i));
            exp_q.push_back(WIDTH'(48 + i));
        end
        wait_wr(2, "stall_reach_beat2");
        @(posedge clk);
        #1;
        fifo_full_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_write_en", {31'd0, fifo_write_en}, 0);
            chk("stall_ready0", {31'd0, req0_ready}, 0);
            chk("stall_ready1", {31'd0, req1_ready}, 0);
`ifdef FIFO_ARB_BURST_EN
            chk("stall_grant", {30'd0, grant}, 1);
`endif
        end
        @(posedge clk);
        #1;
        fifo_full_n = 1'b1;
        tick();
        chk("stall_resume_write_en", {31'd0, fifo_write_en}, 1);
        wait_wr(4, "stall_reach_beat4");
        tick();
        chk("stall_release_after_4", {30'd0, grant}, 0);
        wait_drain("stall_drain");

        // Producer 0 drops valid mid-burst while producer 1 waits
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        start_phase();
        q0.push_back(6'h08);
        q0.push_back(6'h09);
        for (int i = 0; i < 4; i++) q1.push_back(WIDTH'(42 + i));
`ifdef FIFO_ARB_BURST_EN
        exp_q.push_back(6'h08);
        exp_q.push_back(6'h09);
        for (int i = 0; i < 4; i++) exp_q.push_back(WIDTH'(42 + i));
        wait_wr(2, "drop_reach_beat2");
        tick();
        chk("drop_grant_held", {30'd0, grant}, 1);
        chk("drop_no_write", {31'd0, fifo_write_en}, 0);
        tick();
        chk("drop_grant_handover", {30'd0, grant}, 2);
        wait_drain("drop_drain");
        chk("drop_span", last_wr - first_wr, 6);
`else
        exp_q.push_back(6'h08);
        exp_q.push_back(WIDTH'(42));
        exp_q.push_back(6'h09);
        for (int i = 1; i < 4; i++) exp_q.push_back(WIDTH'(42 + i));
        wait_drain("drop_drain");
        chk("drop_span", last_wr - first_wr, 7);
`endif

        // Asynchronous reset during a producer 1 burst
        start_phase();
        for (int i = 0; i < 8; i++) begin
            q1.push_back(WIDTH'(56 + i));
            exp_q.push_back(WIDTH'(56 + i));
        end
        wait_wr(2, "areset_reach_beat2");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset_grant", {30'd0, grant}, 0);
        chk("areset_ready1", {31'd0, req1_ready}, 0);
        chk("areset_write_en", {31'd0, fifo_write_en}, 0);
        chk("areset_fifo_data", {26'd0, fifo_data}, 0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        tick();
        q0.push_back(6'h06);
        q0.push_back(6'h07);
        q1.push_back(6'h3c);
        q1.push_back(6'h3d);
`ifdef FIFO_ARB_BURST_EN
        exp_q.push_back(6'h06);
        exp_q.push_back(6'h07);
        exp_q.push_back(6'h3c);
        exp_q.push_back(6'h3d);
`else
        exp_q.push_back(6'h06);
        exp_q.push_back(6'h3c);
        exp_q.push_back(6'h07);
        exp_q.push_back(6'h3d);
`endif
        tick();
        tick();
        chk("areset_held_write_en", {31'd0, fifo_write_en}, 0);
        reset_n = 1'b1;
        tick();
        chk("areset_first_grant", {30'd0, grant}, 1);
        wait_drain("areset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
